// File: rtl/pipe_stage_latch_pkg.sv
// Shared processor definitions used by pipeline stage registers.
//   state_e    : occupancy state of a two-entry stage latch. The encoding is
//                the entry count, so the state register doubles as the
//                occupancy output and as the FSM debug view.
//   NOP_BUBBLE : default per-field value presented while a stage holds no
//                live entry (instruction NOP / zero PC).
package pipe_stage_latch_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_latch_reg.sv
// Generic enabled register with asynchronous active-low reset.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset, loads RESET_VAL
//   i_en      : load enable
//   i_d       : next value
//   o_q       : registered value
module pipe_stage_latch_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with a skid entry, so that upstream sees a
// registered ready and still gets full throughput.
//   clock      : single clock, rising edge
//   clear_n    : asynchronous active-low reset
//   in_valid   : upstream offers in_data
//   in_ready   : stage accepts in_data (registered)
//   in_data    : NUM_FIELDS packed fields, field k at [k*WIDTH +: WIDTH]
//   out_valid  : out_data holds a live entry
//   out_ready  : downstream consumes out_data
//   out_data   : main register, or BUBBLE in every field when empty
//   flush      : synchronous kill of all held entries
//   occupancy  : held entries 0..2 (also the FSM state)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that side. valid never depends on ready. in_ready is a flop with
// no combinational path from out_ready; in FULL it is 0. A flush cycle
// accepts nothing upstream, but an output transfer in that cycle completes.
module pipe_stage_latch
  import pipe_stage_latch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NUM_FIELDS = 4,
  parameter logic [WIDTH-1:0] BUBBLE     = WIDTH'(NOP_BUBBLE)
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_FIELDS*WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_FIELDS*WIDTH-1:0] out_data,
  input  logic                        flush,
  output logic [1:0]                  occupancy
);

  localparam int                DW         = NUM_FIELDS * WIDTH;
  localparam logic [DW-1:0]     BUBBLE_VEC = {NUM_FIELDS{BUBBLE}};

  state_e        r_state;
  state_e        w_next;
  logic          r_in_ready;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_main_en;
  logic          w_skid_en;
  logic [DW-1:0] w_main_d;
  logic [DW-1:0] w_main_q;
  logic [DW-1:0] w_skid_q;

  // flush masks acceptance, so a discarded input never counts as a transfer.
  assign w_in_xfer  = in_valid & r_in_ready & ~flush;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_next    = r_state;
    w_main_en = 1'b0;
    w_skid_en = 1'b0;
    w_main_d  = in_data;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_next    = ST_ONE;
          w_main_en = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_en = 1'b1;
        end else if (w_in_xfer) begin
          // Main is still owed downstream; park the newcomer in skid.
          w_next    = ST_FULL;
          w_skid_en = 1'b1;
        end else if (w_out_xfer) begin
          w_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_next    = ST_ONE;
          w_main_en = 1'b1;
          w_main_d  = w_skid_q;
        end
      end
      default: begin
        w_next = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_next    = ST_EMPTY;
      w_main_en = 1'b0;
      w_skid_en = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      // Ready is computed from the next state so it is valid from the flop.
      r_in_ready <= (w_next != ST_FULL);
    end
  end

  pipe_stage_latch_reg #(
    .W         (DW),
    .RESET_VAL (BUBBLE_VEC)
  ) u_main (
    .i_clk   (clock),
    .i_rst_n (clear_n),
    .i_en    (w_main_en),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_stage_latch_reg #(
    .W         (DW),
    .RESET_VAL (BUBBLE_VEC)
  ) u_skid (
    .i_clk   (clock),
    .i_rst_n (clear_n),
    .i_en    (w_skid_en),
    .i_d     (in_data),
    .o_q     (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = (r_state == ST_EMPTY) ? BUBBLE_VEC : w_main_q;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_latch.sv
module tb_pipe_stage_latch;

  localparam int W  = 32;
  localparam int NF = 4;
  localparam int DW = W * NF;

  logic          clock;
  logic          clear_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    occupancy;

  int n_tests;
  int n_fail;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [1:0]  eo;
    logic [31:0] ef;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  pipe_stage_latch #(
    .WIDTH      (W),
    .NUM_FIELDS (NF),
    .BUBBLE     (32'h0000_0000)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct value in every field so field mix-ups are visible.
  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {v ^ 32'hFFFF_0000, v + 32'h0000_1000, ~v, v};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] d,
                               input logic ordy, input logic fl,
                               input logic ev, input logic er,
                               input logic [1:0] eo, input logic [31:0] ef);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.er = er; v.eo = eo; v.ef = ef;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = mk(d);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic er,
                            input logic [1:0] eo, input logic [DW-1:0] ed);
    check({tag, " out_valid"}, DW'(out_valid), DW'(ev));
    check({tag, " in_ready"},  DW'(in_ready),  DW'(er));
    check({tag, " occupancy"}, DW'(occupancy), DW'(eo));
    check({tag, " out_data"},  out_data,       ed);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Rows: inputs before the edge, expected outputs after it.
    // Backpressure: 0xA,0xB with out_ready=0, 0xD refused while full.
    vecs[0]  = mkv(1, 32'hA, 0, 0, 1, 1, 2'd1, 32'hA);
    vecs[1]  = mkv(1, 32'hB, 0, 0, 1, 0, 2'd2, 32'hA);
    vecs[2]  = mkv(1, 32'hD, 0, 0, 1, 0, 2'd2, 32'hA);
    vecs[3]  = mkv(0, 32'h0, 1, 0, 1, 1, 2'd1, 32'hB);
    vecs[4]  = mkv(0, 32'h0, 1, 0, 0, 1, 2'd0, 32'h0);
    // Flush while FULL with 0xC offered: 0xC must never appear.
    vecs[5]  = mkv(1, 32'hA, 0, 0, 1, 1, 2'd1, 32'hA);
    vecs[6]  = mkv(1, 32'hB, 0, 0, 1, 0, 2'd2, 32'hA);
    vecs[7]  = mkv(1, 32'hC, 0, 1, 0, 1, 2'd0, 32'h0);
    vecs[8]  = mkv(0, 32'h0, 1, 0, 0, 1, 2'd0, 32'h0);
    // Flush together with an output transfer in ONE.
    vecs[9]  = mkv(1, 32'hA, 0, 0, 1, 1, 2'd1, 32'hA);
    vecs[10] = mkv(0, 32'h0, 1, 1, 0, 1, 2'd0, 32'h0);
    // Pass-through, fill to FULL, hold, drain, flush with input offered in ONE.
    vecs[11] = mkv(1, 32'hA, 1, 0, 1, 1, 2'd1, 32'hA);
    vecs[12] = mkv(1, 32'hB, 1, 0, 1, 1, 2'd1, 32'hB);
    vecs[13] = mkv(1, 32'hE, 0, 0, 1, 0, 2'd2, 32'hB);
    vecs[14] = mkv(0, 32'h0, 0, 0, 1, 0, 2'd2, 32'hB);
    vecs[15] = mkv(0, 32'h0, 1, 0, 1, 1, 2'd1, 32'hE);
    vecs[16] = mkv(1, 32'hF, 0, 1, 0, 1, 2'd0, 32'h0);
    vecs[17] = mkv(0, 32'h0, 1, 0, 0, 1, 2'd0, 32'h0);

    // ---- reset ----
    clear_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    step();
    check_outs("reset_held", 0, 1, 2'd0, '0);
    step();
    clear_n = 1'b1;
    step();
    check_outs("reset_released", 0, 1, 2'd0, '0);

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].eo,
                 vecs[i].ev ? mk(vecs[i].ef) : '0);
    end

    // ---- streaming: 8 PCs, out_ready=1, then drain ----
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      logic iv;
      iv = (i < 8);
      drive(iv, 32'h100 + 32'(4 * i), 1, 0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (iv) exp_q.push_back(mk(32'h100 + 32'(4 * i)));
      step();
      check_outs($sformatf("stream%0d", i), exp_q.size() > 0, 1,
                 2'(exp_q.size()), exp_q.size() > 0 ? exp_q[0] : '0);
    end

    // ---- async reset while FULL, then immediate acceptance ----
    drive(1, 32'hA, 0, 0);
    step();
    drive(1, 32'hB, 0, 0);
    step();
    check_outs("pre_async_full", 1, 0, 2'd2, mk(32'hA));
    drive(0, 32'h0, 0, 0);
    #3;
    clear_n = 1'b0;
    #1;
    check_outs("async_reset", 0, 1, 2'd0, '0);
    #2;
    clear_n = 1'b1;
    drive(1, 32'h77, 0, 0);
    step();
    check_outs("first_after_reset", 1, 1, 2'd1, mk(32'h77));
    drive(0, 32'h0, 1, 0);
    step();
    check_outs("drain_after_reset", 0, 1, 2'd0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the bits per field.
REQ-002 The block SHALL have parameter NUM_FIELDS, default 4, giving the number of fields carried (e.g. PC, IR, A, B).
REQ-003 The block SHALL have parameter BUBBLE, default 0, a WIDTH-bit value driven on every output field while out_valid=0 (NOP insertion).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 clear_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  NUM_FIELDS*WIDTH  packed fields; field k at bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  NUM_FIELDS*WIDTH  packed fields, same layout as in_data.
REQ-012 flush  input  1  synchronous kill of all held entries (branch mispredict / jump).
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Storage SHALL be one main register plus one skid register; states EMPTY (0 entries), ONE (main), FULL (main+skid).
REQ-016 in_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly in ONE and FULL; out_data SHALL always present the main register, or BUBBLE in every field when EMPTY.
REQ-018 EMPTY: input transfer -> ONE, main <= in_data; otherwise stay.
REQ-019 ONE: input+output transfer -> ONE, main <= in_data; input only -> FULL, skid <= in_data; output only -> EMPTY; neither -> stay.
REQ-020 FULL: output transfer -> ONE, main <= skid; otherwise stay, contents unchanged.
REQ-021 Latency in->out SHALL be 1 cycle; sustained throughput SHALL be 1 transfer/cycle while out_ready=1.
REQ-022 flush SHALL take priority over all transitions: next state EMPTY, any input offered that cycle discarded (not accepted, even if in_ready=1), an output transfer in that same cycle still counting as completed.
REQ-023 Entries SHALL leave in strict arrival order; no entry duplicated or lost except by flush.
REQ-024 Holding data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-026 While clear_n=0, state SHALL be EMPTY, main and skid SHALL be BUBBLE in every field, in_ready=1, out_valid=0, occupancy=0, asynchronously.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; first acceptance SHALL be possible on the first rising edge after clear_n rises.

Structure
REQ-028 State encoding (EMPTY/ONE/FULL) and default BUBBLE (NOP) value SHALL live in the shared processor package.
REQ-029 Main and skid storage SHALL each be one instance of the existing codebase register module at NUM_FIELDS*WIDTH bits, enable driven by the FSM; no other sub-module.

Verification
REQ-030 Reset: clear_n=0 then 1 -> out_valid=0, in_ready=1, occupancy=0, out_data all fields 0x00000000.
REQ-031 Streaming: 8 entries, field0=PC 0x100..0x11C step 4, out_ready=1 -> out_data field0 0x100,...,0x11C on consecutive cycles, 1 cycle after each input, occupancy stays 1.
REQ-032 Backpressure: out_ready=0 while sending 0xA, 0xB -> occupancy=2, in_ready=0, out_data=0xA held; out_ready=1 -> 0xA then 0xB, in_ready returns to 1 one cycle after first output transfer.
REQ-033 Flush: FULL holding 0xA,0xB, flush=1 with in_valid=1 data 0xC -> next cycle EMPTY, out_data=BUBBLE, 0xC never appears.
REQ-034 Flush + output transfer same cycle: ONE holding 0xA, out_ready=1, flush=1 -> 0xA counted consumed once, next cycle EMPTY.
REQ-035 Async reset mid-stream: clear_n low between edges while FULL -> outputs at reset values immediately, no edge required.
